// File: rtl/stream_pkg.sv
// Shared definitions for the stream width converter: ratio/mode derivation and
// the elaboration-time width check.
`ifndef STREAM_PARAM_CHECK
`define STREAM_PARAM_CHECK(in_w, out_w) \
   if ((in_w) < 1 || (out_w) < 1 || \
       ((((in_w) > (out_w)) ? (in_w) : (out_w)) % (((in_w) < (out_w)) ? (in_w) : (out_w))) != 0 || \
       stream_pkg::calc_ratio((in_w), (out_w)) > 64) begin : g_param_err \
      $error("stream width converter: widths %0d/%0d need an integer ratio of 1..64", in_w, out_w); \
   end
`endif

package stream_pkg;

   localparam int CNT_W = 6;

   typedef enum logic [1:0] {
      MODE_PASS,
      MODE_UPSIZE,
      MODE_DOWNSIZE
   } mode_e;

   function automatic int calc_ratio(input int in_w, input int out_w);
      return (in_w > out_w) ? (in_w / out_w) : (out_w / in_w);
   endfunction

   function automatic mode_e calc_mode(input int in_w, input int out_w);
      if (in_w == out_w) return MODE_PASS;
      if (out_w > in_w)  return MODE_UPSIZE;
      return MODE_DOWNSIZE;
   endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// One-deep output register with explicit load/drain controls; load wins so a
// reload in the draining cycle keeps valid high without a bubble.
module stream_reg_slice #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         drain,
   input  logic [W-1:0] d,
   output logic         valid,
   output logic [W-1:0] q
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q, data_d;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = 1'b1;
         data_d  = d;
      end else if (drain) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign q     = data_q;

endmodule

// File: rtl/stream_width_converter.sv
// AXI-Stream width converter: packs narrow beats LSB-first into wide words,
// splits wide words into narrow slices, or passes through a register slice.
module stream_width_converter
   import stream_pkg::*;
#(
   parameter int IN_WIDTH  = 8,
   parameter int OUT_WIDTH = 32
) (
   input  logic                 ap_clk,
   input  logic                 ap_rst,
   input  logic [IN_WIDTH-1:0]  in0_V_V_TDATA,
   input  logic                 in0_V_V_TVALID,
   output logic                 in0_V_V_TREADY,
   output logic [OUT_WIDTH-1:0] out_V_V_TDATA,
   output logic                 out_V_V_TVALID,
   input  logic                 out_V_V_TREADY,
   output logic [CNT_W-1:0]     beat_cnt
);

   localparam int               R    = calc_ratio(IN_WIDTH, OUT_WIDTH);
   localparam mode_e            MODE = calc_mode(IN_WIDTH, OUT_WIDTH);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(R - 1);

   `STREAM_PARAM_CHECK(IN_WIDTH, OUT_WIDTH)

   logic [CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
   logic                 in_rdy, in_fire, out_fire, out_vld;
   logic [OUT_WIDTH-1:0] out_dat;

   assign in0_V_V_TREADY = in_rdy & ~ap_rst;
   assign in_fire        = in0_V_V_TVALID & in0_V_V_TREADY;
   assign out_fire       = out_vld & out_V_V_TREADY;
   assign out_V_V_TVALID = out_vld;
   assign out_V_V_TDATA  = out_dat;
   assign beat_cnt       = beat_cnt_q;

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) beat_cnt_q <= '0;
      else        beat_cnt_q <= beat_cnt_d;
   end

   if (MODE == MODE_PASS) begin : g_pass
      stream_reg_slice #(.W(OUT_WIDTH)) u_slice (
         .clk(ap_clk), .rst(ap_rst), .load(in_fire), .drain(out_fire),
         .d(in0_V_V_TDATA), .valid(out_vld), .q(out_dat)
      );
      assign in_rdy     = ~out_vld | out_V_V_TREADY;
      assign beat_cnt_d = '0;
   end else if (MODE == MODE_UPSIZE) begin : g_up
      localparam int ACC_W = OUT_WIDTH - IN_WIDTH;
      logic [ACC_W-1:0] acc_q, acc_d;
      logic             last;

      assign last   = (beat_cnt_q == LAST);
      // Only the completing beat has to wait for room in the output register.
      assign in_rdy = ~last | ~out_vld | out_V_V_TREADY;

      always_comb begin
         acc_d      = acc_q;
         beat_cnt_d = beat_cnt_q;
         if (in_fire) begin
            beat_cnt_d = last ? '0 : beat_cnt_q + 1'b1;
            for (int i = 0; i < R - 1; i++) begin
               if (beat_cnt_q == CNT_W'(i)) acc_d[i*IN_WIDTH +: IN_WIDTH] = in0_V_V_TDATA;
            end
         end
      end

      always_ff @(posedge ap_clk or posedge ap_rst) begin
         if (ap_rst) acc_q <= '0;
         else        acc_q <= acc_d;
      end

      stream_reg_slice #(.W(OUT_WIDTH)) u_slice (
         .clk(ap_clk), .rst(ap_rst), .load(in_fire & last), .drain(out_fire),
         .d({in0_V_V_TDATA, acc_q}), .valid(out_vld), .q(out_dat)
      );
   end else begin : g_down
      logic [IN_WIDTH-1:0] hold;
      logic                last;

      assign last   = (beat_cnt_q == LAST);
      assign in_rdy = ~out_vld | (out_V_V_TREADY & last);

      stream_reg_slice #(.W(IN_WIDTH)) u_slice (
         .clk(ap_clk), .rst(ap_rst), .load(in_fire), .drain(out_fire & last),
         .d(in0_V_V_TDATA), .valid(out_vld), .q(hold)
      );

      always_comb begin
         out_dat = '0;
         for (int i = 0; i < R; i++) begin
            if (beat_cnt_q == CNT_W'(i)) out_dat = hold[i*OUT_WIDTH +: OUT_WIDTH];
         end
      end

      always_comb begin
         beat_cnt_d = beat_cnt_q;
         if (out_fire) beat_cnt_d = last ? '0 : beat_cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_stream_width_converter.sv
// Directed and random checks of the converter in upsize (8->32), downsize
// (32->8) and pass (8->8) configurations, sharing one clock and reset.
module tb_stream_width_converter;

   logic ap_clk = 1'b0;
   logic ap_rst;

   logic [7:0]  u_in_data;  logic u_in_valid, u_in_ready;
   logic [31:0] u_out_data; logic u_out_valid, u_out_ready;
   logic [5:0]  u_beat;

   logic [31:0] d_in_data;  logic d_in_valid, d_in_ready;
   logic [7:0]  d_out_data; logic d_out_valid, d_out_ready;
   logic [5:0]  d_beat;

   logic [7:0]  p_in_data;  logic p_in_valid, p_in_ready;
   logic [7:0]  p_out_data; logic p_out_valid, p_out_ready;
   logic [5:0]  p_beat;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   logic [31:0] up_q[$];
   logic [7:0]  dn_q[$];
   logic [7:0]  p_q[$];
   int          up_cyc[$];
   int          dn_cyc[$];

   int          acc44, widx, p_sent;
   logic        acc, p_acc;
   logic [8:0]  pat;
   logic [31:0] wrd[2];

   stream_width_converter #(.IN_WIDTH(8), .OUT_WIDTH(32)) u_up (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .in0_V_V_TDATA(u_in_data), .in0_V_V_TVALID(u_in_valid), .in0_V_V_TREADY(u_in_ready),
      .out_V_V_TDATA(u_out_data), .out_V_V_TVALID(u_out_valid), .out_V_V_TREADY(u_out_ready),
      .beat_cnt(u_beat)
   );

   stream_width_converter #(.IN_WIDTH(32), .OUT_WIDTH(8)) u_dn (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .in0_V_V_TDATA(d_in_data), .in0_V_V_TVALID(d_in_valid), .in0_V_V_TREADY(d_in_ready),
      .out_V_V_TDATA(d_out_data), .out_V_V_TVALID(d_out_valid), .out_V_V_TREADY(d_out_ready),
      .beat_cnt(d_beat)
   );

   stream_width_converter #(.IN_WIDTH(8), .OUT_WIDTH(8)) u_pass (
      .ap_clk(ap_clk), .ap_rst(ap_rst),
      .in0_V_V_TDATA(p_in_data), .in0_V_V_TVALID(p_in_valid), .in0_V_V_TREADY(p_in_ready),
      .out_V_V_TDATA(p_out_data), .out_V_V_TVALID(p_out_valid), .out_V_V_TREADY(p_out_ready),
      .beat_cnt(p_beat)
   );

   always #5 ap_clk = ~ap_clk;
   always @(posedge ap_clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drain(input string tag);
      for (int k = 0; k < 50 && (up_q.size() + dn_q.size() + p_q.size()) != 0; k++) begin
         @(posedge ap_clk); #1;
      end
      chk(tag, up_q.size() + dn_q.size() + p_q.size(), 0);
   endtask

   // Scoreboard: every output transfer pops the next expected value.
   always @(negedge ap_clk) begin
      logic [31:0] exp_w;
      logic [7:0]  exp_b;
      if (!ap_rst) begin
         if (u_out_valid && u_out_ready) begin
            up_cyc.push_back(cyc);
            exp_w = (up_q.size() != 0) ? up_q.pop_front() : 32'hx;
            chk("up_word", u_out_data, exp_w);
         end
         if (d_out_valid && d_out_ready) begin
            dn_cyc.push_back(cyc);
            exp_b = (dn_q.size() != 0) ? dn_q.pop_front() : 8'hx;
            chk("dn_slice", d_out_data, exp_b);
         end
         if (p_out_valid && p_out_ready) begin
            exp_b = (p_q.size() != 0) ? p_q.pop_front() : 8'hx;
            chk("pass_beat", p_out_data, exp_b);
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ap_rst = 1'b1;
      u_in_data = '0; u_in_valid = 1'b0; u_out_ready = 1'b0;
      d_in_data = '0; d_in_valid = 1'b0; d_out_ready = 1'b0;
      p_in_data = '0; p_in_valid = 1'b0; p_out_ready = 1'b0;
      p_acc = 1'b0; p_sent = 0;

      // Reset state
      @(negedge ap_clk);
      chk("rst_up_in_ready", u_in_ready, 0);
      chk("rst_up_valid", u_out_valid, 0);
      chk("rst_up_data", u_out_data, 0);
      chk("rst_up_beat", u_beat, 0);
      chk("rst_dn_in_ready", d_in_ready, 0);
      chk("rst_dn_data", d_out_data, 0);
      chk("rst_pass_in_ready", p_in_ready, 0);
      @(posedge ap_clk); #1;
      ap_rst = 1'b0;
      @(negedge ap_clk);
      chk("post_rst_up_ready", u_in_ready, 1);
      chk("post_rst_dn_ready", d_in_ready, 1);
      chk("post_rst_pass_ready", p_in_ready, 1);
      @(posedge ap_clk); #1;

      // Upsize, continuous input with the output always ready
      u_out_ready = 1'b1;
      d_out_ready = 1'b1;
      p_out_ready = 1'b1;
      up_cyc.delete();
      up_q.push_back(32'h44332211);
      up_q.push_back(32'h88776655);
      for (int i = 0; i < 8; i++) begin
         u_in_valid = 1'b1;
         u_in_data  = 8'(8'h11 * (i + 1));
         @(negedge ap_clk);
         chk("up_stream_ready", u_in_ready, 1);
         if (i == 3) acc44 = cyc;
         @(posedge ap_clk); #1;
      end
      u_in_valid = 1'b0;
      drain("up_stream_drain");
      chk("up_word_count", up_cyc.size(), 2);
      if (up_cyc.size() == 2) begin
         chk("up_latency", up_cyc[0], acc44 + 1);
         chk("up_period", up_cyc[1] - up_cyc[0], 4);
      end

      // Upsize with the output stalled after the first word
      u_out_ready = 1'b0;
      up_q.push_back(32'h44332211);
      up_q.push_back(32'h88776655);
      for (int i = 0; i < 7; i++) begin
         u_in_valid = 1'b1;
         u_in_data  = 8'(8'h11 * (i + 1));
         @(negedge ap_clk);
         chk("up_stall_accept", u_in_ready, 1);
         @(posedge ap_clk); #1;
      end
      u_in_data = 8'h88;
      for (int i = 0; i < 3; i++) begin
         @(negedge ap_clk);
         chk("up_stall_ready_low", u_in_ready, 0);
         chk("up_stall_valid", u_out_valid, 1);
         chk("up_stall_data", u_out_data, 32'h44332211);
         chk("up_stall_beat", u_beat, 3);
         @(posedge ap_clk); #1;
      end
      u_out_ready = 1'b1;
      @(negedge ap_clk);
      chk("up_release_ready", u_in_ready, 1);
      @(posedge ap_clk); #1;
      u_in_valid = 1'b0;
      @(negedge ap_clk);
      chk("up_reload_valid", u_out_valid, 1);
      chk("up_reload_data", u_out_data, 32'h88776655);
      @(posedge ap_clk); #1;
      drain("up_stall_drain");

      // Upsize reset in the middle of a word
      u_in_valid = 1'b1;
      u_in_data  = 8'hA1;
      @(posedge ap_clk); #1;
      u_in_data  = 8'hA2;
      @(posedge ap_clk); #1;
      u_in_valid = 1'b0;
      @(negedge ap_clk);
      chk("up_mid_word_beat", u_beat, 2);
      #2 ap_rst = 1'b1;
      #1;
      chk("async_rst_beat", u_beat, 0);
      chk("async_rst_valid", u_out_valid, 0);
      chk("async_rst_ready", u_in_ready, 0);
      @(negedge ap_clk);
      #2 ap_rst = 1'b0;
      @(posedge ap_clk); #1;
      up_q.push_back(32'hB4B3B2B1);
      for (int i = 0; i < 4; i++) begin
         u_in_valid = 1'b1;
         u_in_data  = 8'(8'hB1 + i);
         @(negedge ap_clk);
         chk("up_after_rst_ready", u_in_ready, 1);
         @(posedge ap_clk); #1;
      end
      u_in_valid = 1'b0;
      drain("up_after_rst_drain");

      // Downsize, two words back to back
      dn_cyc.delete();
      dn_q.push_back(8'hAA); dn_q.push_back(8'hBB); dn_q.push_back(8'hCC); dn_q.push_back(8'hDD);
      dn_q.push_back(8'h01); dn_q.push_back(8'h02); dn_q.push_back(8'h03); dn_q.push_back(8'h04);
      pat = 9'h111;
      d_in_valid = 1'b1;
      d_in_data  = 32'hDDCCBBAA;
      for (int i = 0; i < 9; i++) begin
         @(negedge ap_clk);
         chk("dn_in_ready_pulse", d_in_ready, pat[i]);
         acc = d_in_valid && d_in_ready;
         @(posedge ap_clk); #1;
         if (acc) begin
            if (d_in_data == 32'hDDCCBBAA) d_in_data = 32'h04030201;
            else                           d_in_valid = 1'b0;
         end
      end
      d_in_valid = 1'b0;
      @(negedge ap_clk);
      chk("dn_valid_drop", d_out_valid, 0);
      chk("dn_beat_wrap", d_beat, 0);
      chk("dn_slice_count", dn_cyc.size(), 8);
      for (int k = 1; k < dn_cyc.size(); k++) chk("dn_consecutive", dn_cyc[k] - dn_cyc[k-1], 1);
      @(posedge ap_clk); #1;

      // Downsize with output ready toggling every cycle
      wrd[0] = 32'h13121110;
      wrd[1] = 32'h17161514;
      for (int i = 0; i < 8; i++) dn_q.push_back(8'(8'h10 + i));
      widx       = 0;
      d_in_valid = 1'b1;
      d_in_data  = wrd[0];
      for (int c = 0; c < 24; c++) begin
         d_out_ready = (c % 2 == 0);
         @(negedge ap_clk);
         acc = d_in_valid && d_in_ready;
         @(posedge ap_clk); #1;
         if (acc) begin
            widx++;
            if (widx < 2) d_in_data = wrd[widx];
            else          d_in_valid = 1'b0;
         end
      end
      d_out_ready = 1'b1;
      drain("dn_bp_drain");
      @(negedge ap_clk);
      chk("dn_bp_idle", d_out_valid, 0);
      @(posedge ap_clk); #1;

      // Pass-through latency with the output ready
      p_out_ready = 1'b1;
      p_in_valid  = 1'b1;
      p_in_data   = 8'h5A;
      p_q.push_back(8'h5A);
      @(negedge ap_clk);
      chk("pass_ready", p_in_ready, 1);
      @(posedge ap_clk); #1;
      p_in_valid = 1'b0;
      @(negedge ap_clk);
      chk("pass_lat_valid", p_out_valid, 1);
      chk("pass_lat_data", p_out_data, 8'h5A);
      @(posedge ap_clk); #1;

      // Pass-through, random valid/ready over 1000 beats
      for (int c = 0; c < 5000 && p_sent < 1000; c++) begin
         if (!p_in_valid || p_acc) begin
            p_in_valid = ($urandom_range(0, 3) != 0);
            p_in_data  = 8'($urandom);
         end
         p_out_ready = ($urandom_range(0, 3) != 0);
         @(negedge ap_clk);
         p_acc = p_in_valid && p_in_ready;
         if (p_acc) begin
            p_q.push_back(p_in_data);
            p_sent++;
         end
         chk("pass_beat_cnt", p_beat, 0);
         @(posedge ap_clk); #1;
      end
      p_in_valid  = 1'b0;
      p_out_ready = 1'b1;
      chk("pass_sent", p_sent, 1000);
      drain("pass_drain");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
